// File: rtl/manage_hp_param.sv
// Two-player HP manager: difficulty-scaled damage with saturation, end-of-game detection
// and an IDLE/PLAY/OVER flow with restart.
module manage_hp_param #(
    parameter int HP_W      = 5,
    parameter int HP_INIT   = 10,
    parameter int DB_W      = 36,
    parameter int LVL_W     = 2,
    parameter int DRAW_MODE = 0,
    parameter int CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             HP_VALID,
    input  logic [1:0]       HP_IN,
    input  logic             DB_VALID,
    input  logic [DB_W-1:0]  DB_IN,
    output logic [HP_W-1:0]  MY_HP_OUT,
    output logic [HP_W-1:0]  ENEMY_HP_OUT,
    output logic [1:0]       RESULT,
    output logic             GAME_OVER,
    output logic [CNT_W-1:0] ROUND_CNT
);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    localparam logic [HP_W-1:0] HP_START = HP_W'(HP_INIT);

    state_t            state, state_next;
    logic [HP_W-1:0]   my_hp, my_next, enemy_hp, enemy_next;
    logic [LVL_W-1:0]  level, level_next;
    logic [1:0]        result, result_next;
    logic [CNT_W-1:0]  round_cnt, cnt_next;
    logic [HP_W-1:0]   dmg, my_sub, enemy_sub;
    logic              unused_db;

    // Only the difficulty field of the question word matters here.
    assign unused_db = ^DB_IN[DB_W-LVL_W-1:0];

    assign dmg       = (level == '0) ? HP_W'(1) : HP_W'(level);
    assign my_sub    = (my_hp > dmg) ? my_hp - dmg : '0;
    assign enemy_sub = (enemy_hp > dmg) ? enemy_hp - dmg : '0;

    always_comb begin
        state_next  = state;
        my_next     = my_hp;
        enemy_next  = enemy_hp;
        result_next = result;
        cnt_next    = round_cnt;
        level_next  = DB_VALID ? DB_IN[DB_W-1 -: LVL_W] : level;
        case (state)
            IDLE: begin
                my_next    = HP_START;
                enemy_next = HP_START;
                if (START) begin
                    state_next  = PLAY;
                    cnt_next    = '0;
                    result_next = '0;
                end
            end
            PLAY: begin
                if (HP_VALID && HP_IN != 2'b00) begin
                    case (HP_IN)
                        2'b01: enemy_next = enemy_sub;
                        2'b10: my_next = my_sub;
                        default: begin
                            if (DRAW_MODE != 0) begin
                                my_next    = my_sub;
                                enemy_next = enemy_sub;
                            end
                        end
                    endcase
                    cnt_next = (&round_cnt) ? round_cnt : round_cnt + CNT_W'(1);
                    // End is judged on the post-damage values so OVER coincides with HP hitting 0.
                    if (my_next == '0 || enemy_next == '0) begin
                        result_next = {my_next == '0, enemy_next == '0};
                        state_next  = OVER;
                    end
                end
            end
            OVER: begin
                if (START) begin
                    state_next  = PLAY;
                    my_next     = HP_START;
                    enemy_next  = HP_START;
                    result_next = '0;
                    cnt_next    = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            my_hp     <= HP_START;
            enemy_hp  <= HP_START;
            level     <= '0;
            result    <= '0;
            round_cnt <= '0;
        end else begin
            state     <= state_next;
            my_hp     <= my_next;
            enemy_hp  <= enemy_next;
            level     <= level_next;
            result    <= result_next;
            round_cnt <= cnt_next;
        end
    end

    assign MY_HP_OUT    = my_hp;
    assign ENEMY_HP_OUT = enemy_hp;
    assign RESULT       = result;
    assign GAME_OVER    = (state == OVER);
    assign ROUND_CNT    = round_cnt;

endmodule

// File: tb/tb_manage_hp_param.sv
// Scoreboard bench for manage_hp_param: two instances (DRAW_MODE 0 and 1) share stimulus,
// hand-computed expectations are queued by the driver and popped by a negedge monitor.
module tb_manage_hp_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        hp_valid = 1'b0;
    logic [1:0]  hp_in = 2'b00;
    logic        db_valid = 1'b0;
    logic [35:0] db_in = '0;

    logic [4:0] my0, en0, my1, en1;
    logic [1:0] res0, res1;
    logic       over0, over1;
    logic [7:0] cnt0, cnt1;

    manage_hp_param #(.DRAW_MODE(0)) dut0 (
        .CLK(clk), .RST(rst), .START(start), .HP_VALID(hp_valid), .HP_IN(hp_in),
        .DB_VALID(db_valid), .DB_IN(db_in), .MY_HP_OUT(my0), .ENEMY_HP_OUT(en0),
        .RESULT(res0), .GAME_OVER(over0), .ROUND_CNT(cnt0)
    );

    manage_hp_param #(.DRAW_MODE(1)) dut1 (
        .CLK(clk), .RST(rst), .START(start), .HP_VALID(hp_valid), .HP_IN(hp_in),
        .DB_VALID(db_valid), .DB_IN(db_in), .MY_HP_OUT(my1), .ENEMY_HP_OUT(en1),
        .RESULT(res1), .GAME_OVER(over1), .ROUND_CNT(cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        int unsigned dut;
        int          my, en, res, over, cnt;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned dut, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, dut, cyc, act, exp);
        end
    endtask

    // Monitor: outputs are registered, so every cycle presents a value; compare the ones that are due.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.due != cyc) begin
                checks++;
                failures++;
                $display("FAIL stale_entry dut%0d: due %0d seen %0d", e.dut, e.due, cyc);
            end else if (e.dut == 0) begin
                chk("my_hp", 0, int'(my0), e.my);
                chk("enemy_hp", 0, int'(en0), e.en);
                chk("result", 0, int'(res0), e.res);
                chk("game_over", 0, int'(over0), e.over);
                chk("round_cnt", 0, int'(cnt0), e.cnt);
            end else begin
                chk("my_hp", 1, int'(my1), e.my);
                chk("enemy_hp", 1, int'(en1), e.en);
                chk("result", 1, int'(res1), e.res);
                chk("game_over", 1, int'(over1), e.over);
                chk("round_cnt", 1, int'(cnt1), e.cnt);
            end
        end
    end

    // One clock of stimulus; expected values describe the outputs after the following edge.
    // The DRAW_MODE=1 instance shares dut0's expectation unless an override is given.
    task automatic step(input logic r, input logic s, input logic hv, input logic [1:0] hin,
                        input logic dv, input logic [1:0] lvl,
                        input int m, input int e, input int rs, input int o, input int c,
                        input int m1 = -1, input int e1 = -1, input int rs1 = -1,
                        input int o1 = -1, input int c1 = -1);
        exp_t x;
        @(posedge clk);
        #1;
        rst      = r;
        start    = s;
        hp_valid = hv;
        hp_in    = hin;
        db_valid = dv;
        db_in    = {lvl, 34'h2_AAAA_5555};
        x.due = cyc + 1;
        x.dut = 0;
        x.my = m; x.en = e; x.res = rs; x.over = o; x.cnt = c;
        sb.push_back(x);
        x.dut  = 1;
        x.my   = (m1 < 0) ? m : m1;
        x.en   = (e1 < 0) ? e : e1;
        x.res  = (rs1 < 0) ? rs : rs1;
        x.over = (o1 < 0) ? o : o1;
        x.cnt  = (c1 < 0) ? c : c1;
        sb.push_back(x);
    endtask

    initial begin
        // reset state and IDLE behaviour
        step(1, 0, 0, 2'b00, 0, 0, 10, 10, 0, 0, 0);
        step(1, 0, 0, 2'b00, 0, 0, 10, 10, 0, 0, 0);
        step(0, 0, 0, 2'b00, 1, 2, 10, 10, 0, 0, 0);
        step(0, 0, 1, 2'b01, 0, 0, 10, 10, 0, 0, 0);
        step(0, 1, 0, 2'b00, 0, 0, 10, 10, 0, 0, 0);
        // level 2 hits on the enemy; START in PLAY ignored; 00 not counted
        step(0, 0, 1, 2'b01, 0, 0, 10, 8, 0, 0, 1);
        step(0, 0, 1, 2'b01, 0, 0, 10, 6, 0, 0, 2);
        step(0, 0, 1, 2'b00, 0, 0, 10, 6, 0, 0, 2);
        step(0, 0, 1, 2'b01, 0, 0, 10, 4, 0, 0, 3);
        step(0, 1, 1, 2'b01, 0, 0, 10, 2, 0, 0, 4);
        step(0, 0, 1, 2'b01, 0, 0, 10, 0, 1, 1, 5);
        // OVER frozen, then restart keeps level 2
        step(0, 0, 1, 2'b10, 0, 0, 10, 0, 1, 1, 5);
        step(0, 1, 0, 2'b00, 0, 0, 10, 10, 0, 0, 0);
        step(0, 0, 1, 2'b01, 0, 0, 10, 8, 0, 0, 1);
        step(0, 0, 1, 2'b01, 0, 0, 10, 6, 0, 0, 2);
        step(0, 0, 1, 2'b01, 0, 0, 10, 4, 0, 0, 3);
        step(0, 0, 1, 2'b01, 0, 0, 10, 2, 0, 0, 4);
        // level 3 against HP 2 saturates at 0
        step(0, 0, 0, 2'b00, 1, 3, 10, 2, 0, 0, 4);
        step(0, 0, 1, 2'b01, 0, 0, 10, 0, 1, 1, 5);
        // START beats HP_VALID in OVER
        step(0, 1, 1, 2'b10, 0, 0, 10, 10, 0, 0, 0);
        // level field 0 costs 1 per hit
        step(0, 0, 0, 2'b00, 1, 0, 10, 10, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            step(0, 0, 1, 2'b10, 0, 0, 9 - i, 10, (i == 9) ? 2 : 0, (i == 9) ? 1 : 0, i + 1);
        step(0, 1, 0, 2'b00, 0, 0, 10, 10, 0, 0, 0);
        // draw at 2/2 with level 2
        step(0, 0, 0, 2'b00, 1, 2, 10, 10, 0, 0, 0);
        step(0, 0, 1, 2'b10, 0, 0, 8, 10, 0, 0, 1);
        step(0, 0, 1, 2'b10, 0, 0, 6, 10, 0, 0, 2);
        step(0, 0, 1, 2'b10, 0, 0, 4, 10, 0, 0, 3);
        step(0, 0, 1, 2'b10, 0, 0, 2, 10, 0, 0, 4);
        step(0, 0, 1, 2'b01, 0, 0, 2, 8, 0, 0, 5);
        step(0, 0, 1, 2'b01, 0, 0, 2, 6, 0, 0, 6);
        step(0, 0, 1, 2'b01, 0, 0, 2, 4, 0, 0, 7);
        step(0, 0, 1, 2'b01, 0, 0, 2, 2, 0, 0, 8);
        step(0, 0, 1, 2'b11, 0, 0, 2, 2, 0, 0, 9, 0, 0, 3, 1, 9);
        step(0, 0, 1, 2'b11, 0, 0, 2, 2, 0, 0, 10, 0, 0, 3, 1, 9);
        // level latch with simultaneous strobe uses the old level
        step(1, 0, 0, 2'b00, 0, 0, 10, 10, 0, 0, 0);
        step(0, 0, 0, 2'b00, 1, 1, 10, 10, 0, 0, 0);
        step(0, 1, 0, 2'b00, 0, 0, 10, 10, 0, 0, 0);
        step(0, 0, 1, 2'b01, 1, 3, 10, 9, 0, 0, 1);
        step(0, 0, 1, 2'b01, 0, 0, 10, 6, 0, 0, 2);
        // RST mid-PLAY overrides a strobe and clears the level
        step(1, 0, 1, 2'b01, 0, 0, 10, 10, 0, 0, 0);
        step(0, 0, 1, 2'b01, 0, 0, 10, 10, 0, 0, 0);
        step(0, 1, 0, 2'b00, 0, 0, 10, 10, 0, 0, 0);
        step(0, 0, 1, 2'b01, 0, 0, 10, 9, 0, 0, 1);
        step(0, 0, 1, 2'b00, 0, 0, 10, 9, 0, 0, 1);
        // round counter saturation using free draws; the DRAW_MODE=1 copy dies after 10
        step(1, 0, 0, 2'b00, 0, 0, 10, 10, 0, 0, 0);
        step(0, 1, 0, 2'b00, 0, 0, 10, 10, 0, 0, 0);
        for (int i = 0; i < 260; i++) begin
            if (i < 10)
                step(0, 0, 1, 2'b11, 0, 0, 10, 10, 0, 0, (i < 255) ? i + 1 : 255,
                     9 - i, 9 - i, (i == 9) ? 3 : 0, (i == 9) ? 1 : 0, i + 1);
            else
                step(0, 0, 1, 2'b11, 0, 0, 10, 10, 0, 0, (i < 255) ? i + 1 : 255,
                     0, 0, 3, 1, 10);
        end
        @(posedge clk);
        #1;
        hp_valid = 1'b0;
        start    = 1'b0;
        db_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
